pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Program-counter sequencer: the consuming end of the branch-target path. Holds the instruction-fetch address, steps it by +1 each cycle, or applies a D-bit signed offset when a branch is taken. Owns the start/done handshake with the testbench/host. Also counts executed cycles. Sits between the decode/branch-target logic and the instruction ROM address port.

## Interface
Parameters:
- D, 12, PC width and width of the signed branch offset
- CW, 16, cycle-counter width

Ports:
- clk  input  1  system clock
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  level request; high = (re)load program start address and hold
- prog_sel  input  2  selects start address from the package start-address list
- branch_taken  input  1  apply `target` this cycle instead of +1
- target  input  D  signed two's-complement PC offset
- halt  input  1  decoded done/halt instruction at current `pc`
- pc  output  D  current fetch address
- fetch_valid  output  1  high when `pc` addresses an instruction being executed
- done  output  1  program finished; held until next `start`
- cycle_count  output  CW  RUN cycles executed since last load; saturating

## Operation
- States:
  - IDLE: reset state; `pc`=0. → LOAD when `start`=1.
  - LOAD: `pc` <= start address for `prog_sel` every cycle; `cycle_count` <= 0; `done`=0. → RUN on the first cycle with `start`=0.
  - RUN: `fetch_valid`=1. Each cycle:
    - `halt`=1 → DONE, `pc` unchanged.
    - else `branch_taken`=1 → `pc` <= `pc` + sign_extend(`target`).
    - else `pc` <= `pc` + 1.
    - `cycle_count` increments each RUN cycle, including the halt cycle.
  - DONE: `done`=1; `pc` and `cycle_count` frozen. → LOAD when `start`=1.
- `start`=1 in RUN → LOAD next cycle (mid-program restart). `start` has priority over `halt` and `branch_taken`.
- Arithmetic: D-bit add, modulo 2^D.
  - `pc`=2^D−1 with +1 wraps to 0.
  - Negative offsets below 0 wrap to the top of the address space.
  - Offset 0 with `branch_taken` holds `pc` (spin); this is legal.
- `prog_sel` values without a defined program map to address 0.
- `cycle_count` saturates at 2^CW−1; no wrap.

## Timing
- All outputs registered. Exception: `fetch_valid` and `done`, which decode state directly; both are glitch-free one-hot state bits.
- Reset values: `pc`=0, `fetch_valid`=0, `done`=0, `cycle_count`=0, state=IDLE.
- Async reset in any state, including mid-RUN: the same values apply immediately. Operation resumes only via `start`.
- Latency:
  - `branch_taken`/`target`/`halt` are sampled at the rising edge in RUN; the new `pc` is visible the following cycle.
  - `done` rises one cycle after the `halt` cycle.
- `prog_sel` is sampled on every LOAD cycle; the last LOAD cycle's value is used.
- `branch_taken` and `halt` are ignored outside RUN.

## Structure
- Shared package `pc_pkg`:
  - state enum `pc_state_t` (IDLE, LOAD, RUN, DONE)
  - start-address constants PROG1_START=12'h000, PROG2_START=12'h100, PROG3_START=12'h200
  - function `start_addr(prog_sel)`
- No sub-module required. The saturating counter may be split out as `sat_counter #(CW)` if reused elsewhere.

## Test plan
- Reset mid-RUN: drive `rst_n`=0 at `pc`=12'h005 → `pc`=0, state IDLE, `done`=0, `fetch_valid`=0 immediately. Raising `start` then proceeds to LOAD normally.
- Start/load: `start`=1 for 3 cycles, `prog_sel`=1, then `start`=0 → `pc`=12'h100 during LOAD. RUN begins and `pc` reads 12'h101 one cycle later.
- Branch offsets:
  - In RUN at `pc`=12'h010, `branch_taken`=1, `target`=12'hFFB (−5) → next `pc`=12'h00B.
  - `target`=12'h014 (+20) from 12'h010 → 12'h024.
  - `target`=0 → `pc` stays at 12'h010.
- Wrap-around:
  - At `pc`=12'hFFF with no branch → `pc`=12'h000.
  - At `pc`=12'h002 with `target`=12'hF88 (−120) → `pc`=12'hF8A.
- Halt/done: `halt` and `branch_taken` together at `pc`=12'h030 after 47 RUN cycles → `pc` stays 12'h030, `done`=1 next cycle, `cycle_count`=48 frozen. `start`=1 → LOAD, `done`=0.
- Saturation: CW=4, run 20 cycles → `cycle_count` holds 15.

Source files
------------

// File: rtl/pc_pkg.sv
// Shared types and program start addresses for the PC sequencer.
package pc_pkg;

    // One-hot encoding so fetch_valid/done can be taken straight from a state bit.
    typedef enum logic [3:0] {
        IDLE = 4'b0001,
        LOAD = 4'b0010,
        RUN  = 4'b0100,
        DONE = 4'b1000
    } pc_state_t;

    localparam int unsigned RUN_BIT  = 2;
    localparam int unsigned DONE_BIT = 3;

    localparam logic [11:0] PROG1_START = 12'h000;
    localparam logic [11:0] PROG2_START = 12'h100;
    localparam logic [11:0] PROG3_START = 12'h200;

    function automatic logic [11:0] start_addr(input logic [1:0] prog_sel);
        logic [11:0] addr;
        case (prog_sel)
            2'd0:    addr = PROG1_START;
            2'd1:    addr = PROG2_START;
            2'd2:    addr = PROG3_START;
            default: addr = 12'h000;
        endcase
        return addr;
    endfunction

endpackage

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: loads a start address, steps or branches the fetch
// address while running, and counts run cycles with saturation.
module pc_sequencer
    import pc_pkg::*;
#(
    parameter int unsigned D  = 12,
    parameter int unsigned CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic          branch_taken,
    input  logic [D-1:0]  target,
    input  logic          halt,
    output logic [D-1:0]  pc,
    output logic          fetch_valid,
    output logic          done,
    output logic [CW-1:0] cycle_count
);

    pc_state_t    state;
    logic [D-1:0] load_addr;
    logic         cnt_full;

    assign load_addr = D'(start_addr(prog_sel));
    assign cnt_full  = &cycle_count;

    assign fetch_valid = state[RUN_BIT];
    assign done        = state[DONE_BIT];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= '0;
            cycle_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) state <= LOAD;
                end
                LOAD: begin
                    pc          <= load_addr;
                    cycle_count <= '0;
                    if (!start) state <= RUN;
                end
                RUN: begin
                    // A restart wins over halt and branch; pc is reloaded in LOAD.
                    if (start) begin
                        state <= LOAD;
                    end else begin
                        if (!cnt_full) cycle_count <= cycle_count + CW'(1);
                        if (halt) begin
                            state <= DONE;
                        end else if (branch_taken) begin
                            // target is already D bits wide, so the add is the sign-extended add.
                            pc <= pc + target;
                        end else begin
                            pc <= pc + D'(1);
                        end
                    end
                end
                DONE: begin
                    if (start) state <= LOAD;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed, table-driven bench for pc_sequencer, with a CW=4 copy for saturation.
module tb_pc_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [1:0]  prog_sel;
    logic        branch_taken;
    logic [11:0] target;
    logic        halt;

    logic [11:0] pc;
    logic        fetch_valid;
    logic        done;
    logic [15:0] cycle_count;

    logic [11:0] pc_s;
    logic        fv_s;
    logic        done_s;
    logic [3:0]  cnt_s;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(.D(12), .CW(16)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prog_sel     (prog_sel),
        .branch_taken (branch_taken),
        .target       (target),
        .halt         (halt),
        .pc           (pc),
        .fetch_valid  (fetch_valid),
        .done         (done),
        .cycle_count  (cycle_count)
    );

    pc_sequencer #(.D(12), .CW(4)) dut_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .prog_sel     (prog_sel),
        .branch_taken (branch_taken),
        .target       (target),
        .halt         (halt),
        .pc           (pc_s),
        .fetch_valid  (fv_s),
        .done         (done_s),
        .cycle_count  (cnt_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        start;
        logic [1:0]  ps;
        logic        bt;
        logic [11:0] tgt;
        logic        halt;
        logic        dc;    // pc/count not checked on this vector
        logic [11:0] pc;
        logic        fv;
        logic        dn;
        logic [15:0] cnt;
    } vec_t;

    localparam int NV = 25;
    vec_t tv[NV];

    function automatic vec_t mk(logic s, logic [1:0] ps, logic bt, logic [11:0] tgt, logic h,
                                logic dc, logic [11:0] p, logic fv, logic dn, logic [15:0] c);
        vec_t v;
        v.start = s;  v.ps = ps;   v.bt = bt; v.tgt = tgt; v.halt = h;
        v.dc    = dc; v.pc = p;    v.fv = fv; v.dn  = dn;  v.cnt  = c;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic step(input logic s, input logic [1:0] ps, input logic bt,
                        input logic [11:0] tgt, input logic h);
        start = s; prog_sel = ps; branch_taken = bt; target = tgt; halt = h;
        @(posedge clk);
        #1;
    endtask

    initial begin
        //            st    ps    bt    tgt      h     dc    pc       fv    dn    cnt
        tv[0]  = mk(1'b1, 2'd1, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 16'd0);
        tv[1]  = mk(1'b1, 2'd1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 1'b0, 1'b0, 16'd0);
        tv[2]  = mk(1'b1, 2'd1, 1'b1, 12'h123, 1'b1, 1'b0, 12'h100, 1'b0, 1'b0, 16'd0);
        tv[3]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h100, 1'b1, 1'b0, 16'd0);
        tv[4]  = mk(1'b0, 2'd1, 1'b0, 12'h000, 1'b0, 1'b0, 12'h101, 1'b1, 1'b0, 16'd1);
        tv[5]  = mk(1'b1, 2'd0, 1'b1, 12'h050, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0, 16'd0);
        tv[6]  = mk(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 16'd0);
        tv[7]  = mk(1'b0, 2'd0, 1'b1, 12'h010, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 16'd1);
        tv[8]  = mk(1'b0, 2'd0, 1'b1, 12'hFFB, 1'b0, 1'b0, 12'h00B, 1'b1, 1'b0, 16'd2);
        tv[9]  = mk(1'b0, 2'd0, 1'b1, 12'h005, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 16'd3);
        tv[10] = mk(1'b0, 2'd0, 1'b1, 12'h014, 1'b0, 1'b0, 12'h024, 1'b1, 1'b0, 16'd4);
        tv[11] = mk(1'b0, 2'd0, 1'b1, 12'hFEC, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 16'd5);
        tv[12] = mk(1'b0, 2'd0, 1'b1, 12'h000, 1'b0, 1'b0, 12'h010, 1'b1, 1'b0, 16'd6);
        tv[13] = mk(1'b0, 2'd0, 1'b0, 12'h7AA, 1'b0, 1'b0, 12'h011, 1'b1, 1'b0, 16'd7);
        tv[14] = mk(1'b0, 2'd0, 1'b1, 12'hFEE, 1'b0, 1'b0, 12'hFFF, 1'b1, 1'b0, 16'd8);
        tv[15] = mk(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h000, 1'b1, 1'b0, 16'd9);
        tv[16] = mk(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h001, 1'b1, 1'b0, 16'd10);
        tv[17] = mk(1'b0, 2'd0, 1'b0, 12'h000, 1'b0, 1'b0, 12'h002, 1'b1, 1'b0, 16'd11);
        tv[18] = mk(1'b0, 2'd0, 1'b1, 12'hF88, 1'b0, 1'b0, 12'hF8A, 1'b1, 1'b0, 16'd12);
        tv[19] = mk(1'b0, 2'd3, 1'b0, 12'h000, 1'b0, 1'b0, 12'hF8B, 1'b1, 1'b0, 16'd13);
        tv[20] = mk(1'b0, 2'd0, 1'b0, 12'h000, 1'b1, 1'b0, 12'hF8B, 1'b0, 1'b1, 16'd14);
        tv[21] = mk(1'b0, 2'd0, 1'b1, 12'h005, 1'b1, 1'b0, 12'hF8B, 1'b0, 1'b1, 16'd14);
        tv[22] = mk(1'b1, 2'd2, 1'b0, 12'h000, 1'b0, 1'b1, 12'h000, 1'b0, 1'b0, 16'd0);
        tv[23] = mk(1'b0, 2'd2, 1'b0, 12'h000, 1'b0, 1'b0, 12'h200, 1'b1, 1'b0, 16'd0);
        tv[24] = mk(1'b0, 2'd2, 1'b0, 12'h000, 1'b0, 1'b0, 12'h201, 1'b1, 1'b0, 16'd1);

        rst_n = 1'b0;
        start = 1'b0; prog_sel = 2'd0; branch_taken = 1'b0; target = 12'h000; halt = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_pc", pc, 12'h000);
        check("reset_fv", fetch_valid, 1'b0);
        check("reset_done", done, 1'b0);
        check("reset_cnt", cycle_count, 16'd0);
        rst_n = 1'b1;
        step(1'b0, 2'd1, 1'b1, 12'h055, 1'b1);
        check("idle_hold_pc", pc, 12'h000);
        check("idle_hold_fv", fetch_valid, 1'b0);

        for (int i = 0; i < NV; i++) begin
            step(tv[i].start, tv[i].ps, tv[i].bt, tv[i].tgt, tv[i].halt);
            if (!tv[i].dc) begin
                check($sformatf("v%0d_pc", i), pc, tv[i].pc);
                check($sformatf("v%0d_cnt", i), cycle_count, tv[i].cnt);
                check($sformatf("v%0d_sat_cnt", i), cnt_s,
                      (tv[i].cnt > 16'd15) ? 4'd15 : tv[i].cnt[3:0]);
                check($sformatf("v%0d_sat_pc", i), pc_s, tv[i].pc);
            end
            check($sformatf("v%0d_fv", i), fetch_valid, tv[i].fv);
            check($sformatf("v%0d_done", i), done, tv[i].dn);
        end

        // Halt together with branch after 47 run cycles; undefined prog_sel loads 0.
        step(1'b1, 2'd3, 1'b0, 12'h000, 1'b0);
        step(1'b0, 2'd3, 1'b0, 12'h000, 1'b0);
        check("sel3_pc", pc, 12'h000);
        check("sel3_fv", fetch_valid, 1'b1);
        for (int k = 1; k <= 46; k++) begin
            step(1'b0, 2'd0, 1'b0, 12'h000, 1'b0);
            if (k == 14) check("sat_14", cnt_s, 4'd14);
            if (k == 15) check("sat_15", cnt_s, 4'd15);
            if (k == 16) check("sat_16", cnt_s, 4'd15);
            if (k == 20) begin
                check("cnt_20", cycle_count, 16'd20);
                check("sat_20", cnt_s, 4'd15);
            end
        end
        check("run46_pc", pc, 12'h02E);
        check("run46_cnt", cycle_count, 16'd46);
        step(1'b0, 2'd0, 1'b1, 12'h002, 1'b0);
        check("run47_pc", pc, 12'h030);
        check("run47_cnt", cycle_count, 16'd47);
        check("run47_done", done, 1'b0);
        step(1'b0, 2'd0, 1'b1, 12'h007, 1'b1);
        check("halt_pc", pc, 12'h030);
        check("halt_done", done, 1'b1);
        check("halt_fv", fetch_valid, 1'b0);
        check("halt_cnt", cycle_count, 16'd48);
        check("halt_sat_cnt", cnt_s, 4'd15);
        check("halt_sat_done", done_s, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step(1'b0, 2'd1, 1'b1, 12'h003, 1'b1);
            check($sformatf("frozen%0d_pc", k), pc, 12'h030);
            check($sformatf("frozen%0d_cnt", k), cycle_count, 16'd48);
            check($sformatf("frozen%0d_done", k), done, 1'b1);
        end
        step(1'b1, 2'd0, 1'b0, 12'h000, 1'b0);
        check("reload_done", done, 1'b0);
        check("reload_fv", fetch_valid, 1'b0);

        // Asynchronous reset in the middle of RUN.
        step(1'b0, 2'd0, 1'b0, 12'h000, 1'b0);
        check("rerun_pc", pc, 12'h000);
        check("rerun_cnt", cycle_count, 16'd0);
        repeat (5) step(1'b0, 2'd0, 1'b0, 12'h000, 1'b0);
        check("pre_rst_pc", pc, 12'h005);
        check("pre_rst_fv", fetch_valid, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_pc", pc, 12'h000);
        check("async_rst_fv", fetch_valid, 1'b0);
        check("async_rst_done", done, 1'b0);
        check("async_rst_cnt", cycle_count, 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        step(1'b0, 2'd2, 1'b0, 12'h000, 1'b0);
        check("post_rst_idle_pc", pc, 12'h000);
        check("post_rst_idle_fv", fetch_valid, 1'b0);
        step(1'b1, 2'd2, 1'b0, 12'h000, 1'b0);
        step(1'b1, 2'd2, 1'b0, 12'h000, 1'b0);
        check("post_rst_load_pc", pc, 12'h200);
        check("post_rst_load_fv", fetch_valid, 1'b0);
        step(1'b0, 2'd2, 1'b0, 12'h000, 1'b0);
        check("post_rst_run_pc", pc, 12'h200);
        check("post_rst_run_fv", fetch_valid, 1'b1);
        step(1'b0, 2'd2, 1'b0, 12'h000, 1'b0);
        check("post_rst_step_pc", pc, 12'h201);
        check("post_rst_step_cnt", cycle_count, 16'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
